// File: rtl/cpu_pkg.sv
// Shared definitions for the 301 16-bit RISC core: datapath width,
// opcode constants, ALU operation encodings and the 8-bit sign extender
// used for PC-relative branches.
package cpu_pkg;

    localparam int WIDTH = 16;

    // Opcodes occupy IR[15:9]
    localparam logic [6:0] OP_ADD  = 7'h70;
    localparam logic [6:0] OP_SUB  = 7'h71;
    localparam logic [6:0] OP_AND  = 7'h72;
    localparam logic [6:0] OP_OR   = 7'h73;
    localparam logic [6:0] OP_XOR  = 7'h74;
    localparam logic [6:0] OP_NOT  = 7'h75;
    localparam logic [6:0] OP_SL   = 7'h76;
    localparam logic [6:0] OP_SR   = 7'h77;
    localparam logic [6:0] OP_LDI  = 7'h78;
    localparam logic [6:0] OP_LD   = 7'h79;
    localparam logic [6:0] OP_STO  = 7'h7A;
    localparam logic [6:0] OP_JMP  = 7'h7B;
    localparam logic [6:0] OP_BRZ  = 7'h7C;
    localparam logic [6:0] OP_BRN  = 7'h7D;
    localparam logic [6:0] OP_BR   = 7'h7E;
    localparam logic [6:0] OP_HALT = 7'h7F;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NOT  = 3'd5,
        ALU_SL   = 3'd6,
        ALU_SR   = 3'd7
    } alu_op_t;

    // Replicate bit 7 into the upper bits of a WIDTH-bit word
    function automatic logic [WIDTH-1:0] sext8(input logic [7:0] x);
        return {{(WIDTH-8){x[7]}}, x};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selector.
// Ports: pc (current PC), ir_lo (IR[7:0] branch offset), s_in (jump
// target), pc_ld / pc_inc / pc_sel strobes -> next_pc.
// pc_ld has priority over pc_inc; with neither, the PC holds.
module pc_next #(
    parameter int W = 16
) (
    input  logic [W-1:0] pc,
    input  logic [7:0]   ir_lo,
    input  logic [W-1:0] s_in,
    input  logic         pc_ld,
    input  logic         pc_inc,
    input  logic         pc_sel,
    output logic [W-1:0] next_pc
);
    import cpu_pkg::*;

    logic signed [WIDTH-1:0] off16;
    logic        [W-1:0]     offset;

    // Signed size cast sign-extends (or truncates) the offset to W bits
    assign off16  = signed'(sext8(ir_lo));
    assign offset = W'(off16);

    always_comb begin
        next_pc = pc;
        if (pc_ld)
            next_pc = pc_sel ? s_in : pc + offset;
        else if (pc_inc)
            next_pc = pc + W'(1);
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Instruction-side datapath: program counter, instruction register and
// memory address mux, plus debug support (saturating retired-instruction
// counter and sticky PC breakpoint flag).
// Ports: clk, reset (sync, active high); control strobes pc_ld, pc_inc,
// pc_sel, ir_ld, adr_sel; R_in/S_in from the register file; D_in memory
// read data; bp_en/bp_addr/bp_clr breakpoint controls.
// Outputs: Address, IR, PC, inst_cnt, bp_hit.
module pc_ir_unit #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_ld,
    input  logic                 pc_inc,
    input  logic                 pc_sel,
    input  logic                 ir_ld,
    input  logic                 adr_sel,
    input  logic [WIDTH-1:0]     R_in,
    input  logic [WIDTH-1:0]     S_in,
    input  logic [WIDTH-1:0]     D_in,
    input  logic                 bp_en,
    input  logic [WIDTH-1:0]     bp_addr,
    input  logic                 bp_clr,
    output logic [WIDTH-1:0]     Address,
    output logic [WIDTH-1:0]     IR,
    output logic [WIDTH-1:0]     PC,
    output logic [CNT_WIDTH-1:0] inst_cnt,
    output logic                 bp_hit
);
    logic [WIDTH-1:0] next_pc;
    logic             hit;

    pc_next #(.W(WIDTH)) u_pc_next (
        .pc      (PC),
        .ir_lo   (IR[7:0]),
        .s_in    (S_in),
        .pc_ld   (pc_ld),
        .pc_inc  (pc_inc),
        .pc_sel  (pc_sel),
        .next_pc (next_pc)
    );

    // Memory is asynchronous-read, so the address must be combinational
    assign Address = adr_sel ? R_in : PC;

    // PC still holds the address of the word being fetched this cycle
    assign hit = ir_ld && bp_en && (PC == bp_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            PC       <= RESET_PC;
            IR       <= '0;
            inst_cnt <= '0;
            bp_hit   <= 1'b0;
        end else begin
            PC <= next_pc;
            if (ir_ld)
                IR <= D_in;
            if (ir_ld && !(&inst_cnt))
                inst_cnt <= inst_cnt + CNT_WIDTH'(1);
            // A new hit beats a simultaneous clear
            if (hit)
                bp_hit <= 1'b1;
            else if (bp_clr)
                bp_hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;
    logic        clk;
    logic        reset;
    logic        pc_ld, pc_inc, pc_sel, ir_ld, adr_sel;
    logic [15:0] R_in, S_in, D_in;
    logic        bp_en, bp_clr;
    logic [15:0] bp_addr;
    logic [15:0] Address, IR, PC, inst_cnt;
    logic        bp_hit;

    int vectors     = 0;
    int miscompares = 0;

    pc_ir_unit #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_ld    (pc_ld),
        .pc_inc   (pc_inc),
        .pc_sel   (pc_sel),
        .ir_ld    (ir_ld),
        .adr_sel  (adr_sel),
        .R_in     (R_in),
        .S_in     (S_in),
        .D_in     (D_in),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .bp_clr   (bp_clr),
        .Address  (Address),
        .IR       (IR),
        .PC       (PC),
        .inst_cnt (inst_cnt),
        .bp_hit   (bp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pc_ld = 0; pc_inc = 0; pc_sel = 0; ir_ld = 0; adr_sel = 0; bp_clr = 0;
    endtask

    task automatic jump(input logic [15:0] tgt);
        S_in = tgt; pc_ld = 1; pc_sel = 1;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1; R_in = 0; S_in = 0; D_in = 0; bp_en = 0; bp_addr = 0;

        // Reset state
        step(); step();
        chk("rst_pc", PC, 16'h0000);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_cnt", inst_cnt, 16'h0000);
        chk("rst_bp", bp_hit, 1'b0);
        chk("rst_addr", Address, 16'h0000);

        // Fetch
        reset = 0; D_in = 16'hE0C1; ir_ld = 1; pc_inc = 1;
        step(); idle();
        chk("fetch_pc", PC, 16'h0001);
        chk("fetch_ir", IR, 16'hE0C1);
        chk("fetch_cnt", inst_cnt, 16'h0001);
        chk("fetch_addr", Address, 16'h0001);

        // Walk PC to 5
        pc_inc = 1;
        repeat (4) step();
        idle();
        chk("inc_pc", PC, 16'h0005);

        // Backward branch: 5 + (-2) = 3
        D_in = 16'hF8FE; ir_ld = 1; step(); idle();
        chk("br_ir", IR, 16'hF8FE);
        chk("br_pc_hold", PC, 16'h0005);
        pc_ld = 1; pc_sel = 0; step(); idle();
        chk("br_back", PC, 16'h0003);

        // Forward branch: 3 + 7F = 82
        D_in = 16'h007F; ir_ld = 1; step(); idle();
        pc_ld = 1; step(); idle();
        chk("br_fwd", PC, 16'h0082);

        // Jump with pc_inc also high: load wins
        S_in = 16'h1234; pc_ld = 1; pc_sel = 1; pc_inc = 1; step(); idle();
        chk("jmp_prio", PC, 16'h1234);

        // Address mux
        adr_sel = 1; R_in = 16'h00A0; #1;
        chk("addr_r_comb", Address, 16'h00A0);
        step();
        chk("addr_r_pc", PC, 16'h1234);
        chk("addr_r_reg", Address, 16'h00A0);
        adr_sel = 0; #1;
        chk("addr_pc", Address, 16'h1234);

        // Wrap on increment
        jump(16'hFFFF);
        chk("wrap_pre", PC, 16'hFFFF);
        pc_inc = 1; step(); idle();
        chk("wrap_inc", PC, 16'h0000);

        // Wrap on relative branch: 0 + (-1)
        D_in = 16'h00FF; ir_ld = 1; step(); idle();
        pc_ld = 1; pc_sel = 0; step(); idle();
        chk("wrap_br", PC, 16'hFFFF);

        // Breakpoint disabled: no hit
        bp_addr = 16'h0003; bp_en = 0;
        jump(16'h0003);
        D_in = 16'h1111; ir_ld = 1; pc_inc = 1; step(); idle();
        chk("bp_dis", bp_hit, 1'b0);
        chk("bp_dis_pc", PC, 16'h0004);

        // Breakpoint hit at PC 3
        jump(16'h0003);
        bp_en = 1; ir_ld = 1; pc_inc = 1; step(); idle();
        chk("bp_hit", bp_hit, 1'b1);
        ir_ld = 1; pc_inc = 1; step(); idle();
        chk("bp_sticky", bp_hit, 1'b1);
        chk("bp_sticky_pc", PC, 16'h0005);
        bp_en = 0; step();
        chk("bp_en0_hold", bp_hit, 1'b1);
        bp_clr = 1; step(); idle();
        chk("bp_clr", bp_hit, 1'b0);

        // Hit and clear together: set wins
        jump(16'h0003);
        bp_en = 1; bp_clr = 1; ir_ld = 1; pc_inc = 1; step(); idle();
        chk("bp_set_wins", bp_hit, 1'b1);
        // Clear with a fetch that misses (PC 4)
        bp_clr = 1; ir_ld = 1; pc_inc = 1; step(); idle();
        chk("bp_clr_miss", bp_hit, 1'b0);

        // Reset mid-operation discards the increment
        pc_inc = 1; ir_ld = 1; reset = 1; step(); idle(); reset = 0;
        chk("rst_mid_pc", PC, 16'h0000);
        chk("rst_mid_cnt", inst_cnt, 16'h0000);
        chk("rst_mid_ir", IR, 16'h0000);

        // Counter saturation
        bp_en = 0; ir_ld = 1;
        repeat (65534) step();
        chk("cnt_fffe", inst_cnt, 16'hFFFE);
        step();
        chk("cnt_sat", inst_cnt, 16'hFFFF);
        step();
        chk("cnt_no_wrap", inst_cnt, 16'hFFFF);
        idle(); reset = 1; step(); reset = 0;
        chk("cnt_rst", inst_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Instruction-side datapath stage of the 301 16-bit RISC processor.
- Holds the program counter (PC) and instruction register (IR).
- Sits directly upstream of the control unit: it supplies IR to the control unit and consumes the control unit's pc_ld, pc_inc, pc_sel, ir_ld and adr_sel.
- Drives the memory address bus.
- Also provides debug support for the board LEDs and test harness: a retired-instruction counter and a sticky PC breakpoint flag.

Parameters:
- WIDTH, 16, data/address/instruction width.
- RESET_PC, 16'h0000, value loaded into PC on reset.
- CNT_WIDTH, 16, width of the instruction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- pc_ld  input  1  load PC with the branch/jump target.
- pc_inc  input  1  PC <- PC+1.
- pc_sel  input  1  target select: 0 = PC + sign-extended IR[7:0]; 1 = S_in.
- ir_ld  input  1  IR <- D_in.
- adr_sel  input  1  address select: 0 = PC; 1 = R_in.
- R_in  input  WIDTH  register-file R port (LD/STO address).
- S_in  input  WIDTH  register-file S port (JMP target).
- D_in  input  WIDTH  memory read data.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  WIDTH  breakpoint address.
- bp_clr  input  1  clears bp_hit.
- Address  output  WIDTH  memory address.
- IR  output  WIDTH  instruction register, to the control unit.
- PC  output  WIDTH  current PC.
- inst_cnt  output  CNT_WIDTH  count of ir_ld events, saturating.
- bp_hit  output  1  sticky breakpoint-hit flag.

Behaviour:
- Reset (synchronous, overrides everything):
  - PC = RESET_PC, IR = 0, inst_cnt = 0, bp_hit = 0.
  - Address therefore reads RESET_PC when adr_sel = 0.
- Address (combinational):
  - Address = adr_sel ? R_in : PC.
  - Zero latency; memory is an asynchronous read, so D_in is valid in the same cycle.
- PC update priority, at posedge:
  - pc_ld = 1: PC <= pc_sel ? S_in : PC + sext(IR[7:0]).
  - Else pc_inc = 1: PC <= PC + 1.
  - Else PC holds.
  - pc_ld and pc_inc asserted together: pc_ld wins; no increment is applied.
- Arithmetic:
  - All PC arithmetic is modulo 2^WIDTH; 16'hFFFF + 1 = 16'h0000.
  - A relative branch is relative to the already-incremented PC, because FETCH increments PC.
  - sext replicates IR[7] into bits WIDTH-1:8.
- IR:
  - ir_ld = 1: IR <= D_in.
  - Otherwise IR holds.
  - In the FETCH cycle ir_ld and pc_inc are both high: IR captures M[old PC] and PC becomes old PC + 1 on the same edge.
- inst_cnt:
  - Increments by 1 on each cycle with ir_ld = 1.
  - Saturates at all-ones and never wraps.
- bp_hit:
  - Set at the posedge where ir_ld = 1, bp_en = 1 and PC == bp_addr (address of the instruction being fetched).
  - Stays set until reset or bp_clr.
  - bp_clr = 1 with a new hit in the same cycle: set wins.
  - bp_en = 0 never sets bp_hit and does not clear it.
- No internal FSM beyond these registers. Sequencing is owned by the control unit; this block reacts only to strobes.
- Reset mid-operation discards any pending load or increment in that cycle.

Decomposition:
- Shared package cpu_pkg:
  - WIDTH constant.
  - Opcode constants (7'h70..7'h7F).
  - alu_op encodings.
  - The function sext8(x).
  - The control unit and execution unit use the same package.
- One sub-module, pc_next: combinational next-PC selector taking PC, IR[7:0], S_in, pc_ld, pc_inc, pc_sel and producing next PC.
- Top level holds the registers, address mux, counter and breakpoint logic.

Test Plan:
- Reset, then fetch: reset high for 2 cycles, D_in = 16'hE0C1, one cycle of ir_ld = pc_inc = 1 -> PC = 0001, IR = E0C1, inst_cnt = 1, Address = 0001.
- Backward branch: PC = 0005, IR = 16'hF8FE, pc_ld = 1, pc_sel = 0 -> PC = 0003. Then IR[7:0] = 7F -> PC = 0082.
- Jump and priority: S_in = 1234, pc_ld = pc_sel = pc_inc = 1 -> PC = 1234, not 1235. Separately, adr_sel = 1 with R_in = 00A0 -> Address = 00A0 while PC is unchanged.
- Wrap: PC = FFFF, pc_inc -> 0000. PC = 0000, IR[7:0] = FF, pc_ld -> FFFF.
- Breakpoint: bp_en = 1, bp_addr = 0003; fetch at PC = 3 -> bp_hit = 1 from the next cycle and remains 1 across later fetches. bp_clr pulse -> 0. Hit and bp_clr in the same cycle -> 1.
- Saturation: preload the counter via 65 535 fetches (or a CNT_WIDTH = 4 build: 15 fetches) -> inst_cnt = all-ones after a further ir_ld, and reset returns it to 0.
